// File: rtl/add4_tester_if.sv
// Adder-board bus: operand drive, sum readback, start button and LED status.
interface add4_tester_if;
    logic       start;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [4:0] sum_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [3:0] fail_a;
    logic [3:0] fail_b;

    modport master (
        input  start, sum_in,
        output a_out, b_out, busy, done, pass, err_count, fail_a, fail_b
    );

    modport slave (
        output start, sum_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_a, fail_b
    );
endinterface

// File: rtl/add4_tester.sv
// Sweeps all 256 operand pairs into the 4-bit adder board and checks each sum.
// Optional ADD4_TESTER_STOP_ON_FAIL_EN: halt on the first mismatching pair.
module add4_tester #(
    parameter int SETTLE_CYCLES = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    add4_tester_if.master bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

    state_t     state, state_n;
    logic       start_s1, start_s2, start_d;
    logic [4:0] sum_s1, sum_s2;
    logic [7:0] idx;
    logic [7:0] cnt;
    logic       start_edge;
    logic       mismatch;
    logic       last;

    assign start_edge = start_s2 & ~start_d;
    assign mismatch   = sum_s2 != ({1'b0, bus.a_out} + {1'b0, bus.b_out});
    assign last       = idx == 8'hff;

    // Both the button and the adder result are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            sum_s1   <= '0;
            sum_s2   <= '0;
        end else begin
            start_s1 <= bus.start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            sum_s1   <= bus.sum_in;
            sum_s2   <= sum_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start_edge) state_n = DRIVE;
            DRIVE:      state_n = SETTLE;
            SETTLE:     if (cnt == 8'd0) state_n = SAMPLE;
`ifdef ADD4_TESTER_STOP_ON_FAIL_EN
            SAMPLE:     state_n = (last || mismatch) ? DONE : DRIVE;
`else
            SAMPLE:     state_n = last ? DONE : DRIVE;
`endif
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            cnt           <= '0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.fail_a    <= '0;
            bus.fail_b    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        idx           <= '0;
                        bus.err_count <= '0;
                        bus.fail_a    <= '0;
                        bus.fail_b    <= '0;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end
                DRIVE: begin
                    bus.a_out <= idx[7:4];
                    bus.b_out <= idx[3:0];
                    cnt       <= 8'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (bus.err_count != 8'hff) bus.err_count <= bus.err_count + 8'd1;
                        // Zero count means this is the first failing pair of the sweep.
                        if (bus.err_count == 8'd0) begin
                            bus.fail_a <= bus.a_out;
                            bus.fail_b <= bus.b_out;
                        end
                    end
                    if (state_n == DONE) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= ~mismatch & (bus.err_count == 8'd0);
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add4_tester.sv
// Scoreboard bench for add4_tester with a faultable adder model on sum_in.
module tb_add4_tester;
    localparam int SETTLE = 3;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [3:0] fa, fb, la, lb;
        int         cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   fault = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [4:0] model_sum;

    add4_tester_if bus();
    add4_tester #(.SETTLE_CYCLES(SETTLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;

    always_comb begin
        model_sum = {1'b0, bus.a_out} + {1'b0, bus.b_out};
        if (fault == 1) model_sum[4] = 1'b0;
        if (fault == 2) model_sum[0] = ~model_sum[0];
    end
    assign bus.sum_in = model_sum;

    function automatic exp_t model(input int mode);
        exp_t e;
        int errs = 0;
        int done_pairs = 0;
        logic [4:0] good, bad;
        e.fa = 0; e.fb = 0; e.la = 0; e.lb = 0;
        for (int p = 0; p < 256; p++) begin
            logic [3:0] a, b;
            a = 4'(p / 16);
            b = 4'(p % 16);
            good = 5'(int'(a) + int'(b));
            bad  = good;
            if (mode == 1) bad[4] = 1'b0;
            if (mode == 2) bad[0] = ~bad[0];
            done_pairs++;
            e.la = a; e.lb = b;
            if (bad != good) begin
                if (errs == 0) begin e.fa = a; e.fb = b; end
                errs++;
`ifdef ADD4_TESTER_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        e.err    = (errs > 255) ? 8'd255 : 8'(errs);
        e.pass   = (errs == 0);
        e.cycles = done_pairs * (SETTLE + 2);
        return e;
    endfunction

    task automatic run_sweep(input int mode, input int repulse);
        exp_t e;
        int n, cyc, hold;
        bit pulsed;
        fault = mode;
        sb.push_back(model(mode));
        @(negedge clk);
        bus.start = 1'b1;
        n = 0;
        while (bus.busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_accept busy=%b want 1", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL done_cleared done=%b want 0", bus.done); end
        cyc = 0; hold = 0; pulsed = 0;
        while (bus.busy === 1'b1 && cyc < 3000) begin
            cyc++;
            if (!pulsed && repulse >= 0 && {bus.a_out, bus.b_out} == repulse[7:0]) begin
                bus.start = 1'b1; hold = 3; pulsed = 1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (cyc !== e.cycles) begin errors++; $display("FAIL busy_cycles got=%0d want=%0d", cyc, e.cycles); end
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL done got=%b want=1", bus.done); end
        checks++;
        if (bus.pass !== e.pass) begin errors++; $display("FAIL pass got=%b want=%b", bus.pass, e.pass); end
        checks++;
        if (bus.err_count !== e.err) begin errors++; $display("FAIL err_count got=%0d want=%0d", bus.err_count, e.err); end
        checks++;
        if ({bus.fail_a, bus.fail_b} !== {e.fa, e.fb})
            begin errors++; $display("FAIL fail_pair got=%0d,%0d want=%0d,%0d", bus.fail_a, bus.fail_b, e.fa, e.fb); end
        checks++;
        if ({bus.a_out, bus.b_out} !== {e.la, e.lb})
            begin errors++; $display("FAIL last_pair got=%0d,%0d want=%0d,%0d", bus.a_out, bus.b_out, e.la, e.lb); end
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin errors++; $display("FAIL done_hold done/busy=%b want 10", {bus.done, bus.busy}); end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_a, bus.fail_b, bus.a_out, bus.b_out} !== 27'd0)
            begin errors++; $display("FAIL reset_outputs got nonzero want 0"); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset busy/done=%b want 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_clean();      run_sweep(0, -1); endtask
    task automatic test_bit4_stuck(); run_sweep(1, -1); endtask
    task automatic test_saturate();   run_sweep(2, -1); endtask
    task automatic test_restart_ignored(); run_sweep(0, 40); endtask

    task automatic test_abort();
        int n;
        fault = 0;
        @(negedge clk);
        bus.start = 1'b1;
        n = 0;
        while (bus.busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        n = 0;
        while ({bus.a_out, bus.b_out} !== 8'd100 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if ({bus.a_out, bus.b_out} !== 8'd100) begin errors++; $display("FAIL reach_idx100 got=%0d want=100", {bus.a_out, bus.b_out}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_a, bus.fail_b, bus.a_out, bus.b_out} !== 27'd0)
            begin errors++; $display("FAIL async_abort got nonzero busy=%b a=%0d b=%0d want 0", bus.busy, bus.a_out, bus.b_out); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({bus.busy, bus.a_out, bus.b_out} !== 9'd0) begin errors++; $display("FAIL no_resume busy=%b a=%0d b=%0d want 0", bus.busy, bus.a_out, bus.b_out); end
        run_sweep(0, -1);
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_clean();
        test_bit4_stuck();
        test_saturate();
        test_restart_ignored();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
